// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================
// pipeline_pkg : shared types/constants for hazard control
// Revision 1.0
// ============================================================
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO            = 5'd0;
  localparam int         DEFAULT_MEM_TIMEOUT = 200;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================
// sat_counter : enable-driven up counter that sticks at all-ones
// Revision 1.0
// ============================================================
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================
// pipeline_hazard_ctrl : stall/flush sequencer for the 5-stage pipe
// Revision 1.0
// ============================================================
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rd,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             PCwrite,
  output logic             IF_IDwrite,
  output logic             ID_EXwrite,
  output logic             EX_MEMwrite,
  output logic             control_sel,
  output logic             if_id_flush,
  output logic             mem_wb_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Last wait count value from which the next unready cycle halts.
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_q, wait_d;

  logic loaduse;
  logic memwait;
  logic apply_run;
  logic br_flush;

  assign loaduse = id_ex_memread && (id_ex_rd != REG_ZERO) &&
                   ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
  assign memwait = dmem_req && !dmem_ready;

  always_comb begin
    PCwrite       = 1'b1;
    IF_IDwrite    = 1'b1;
    ID_EXwrite    = 1'b1;
    EX_MEMwrite   = 1'b1;
    control_sel   = 1'b0;
    if_id_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    br_flush      = 1'b0;
    apply_run     = 1'b0;
    state_d       = state_q;
    wait_d        = wait_q;

    case (state_q)
      RUN: apply_run = 1'b1;
      MEM_WAIT: begin
        if (dmem_ready) begin
          apply_run = 1'b1;
          state_d   = RUN;
          wait_d    = '0;
        end else begin
          PCwrite       = 1'b0;
          IF_IDwrite    = 1'b0;
          ID_EXwrite    = 1'b0;
          EX_MEMwrite   = 1'b0;
          mem_wb_bubble = 1'b1;
          if (wait_q >= TIMEOUT_LAST) begin
            state_d = HALT;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      HALT: begin
        PCwrite       = 1'b0;
        IF_IDwrite    = 1'b0;
        ID_EXwrite    = 1'b0;
        EX_MEMwrite   = 1'b0;
        control_sel   = 1'b1;
        mem_wb_bubble = 1'b1;
      end
      default: begin
        PCwrite       = 1'b0;
        IF_IDwrite    = 1'b0;
        ID_EXwrite    = 1'b0;
        EX_MEMwrite   = 1'b0;
        control_sel   = 1'b1;
        mem_wb_bubble = 1'b1;
        state_d       = RUN;
        wait_d        = '0;
      end
    endcase

    // Priority: memory wait freezes everything, then branch flush, then load-use.
    if (apply_run) begin
      if (memwait) begin
        PCwrite       = 1'b0;
        IF_IDwrite    = 1'b0;
        ID_EXwrite    = 1'b0;
        EX_MEMwrite   = 1'b0;
        mem_wb_bubble = 1'b1;
        state_d       = MEM_WAIT;
        wait_d        = TIMEOUT_W'(1);
      end else if (branch_taken) begin
        if_id_flush = 1'b1;
        control_sel = 1'b1;
        br_flush    = 1'b1;
      end else if (loaduse) begin
        PCwrite     = 1'b0;
        IF_IDwrite  = 1'b0;
        control_sel = 1'b1;
      end
    end

    if (reset) begin
      PCwrite       = 1'b0;
      IF_IDwrite    = 1'b0;
      ID_EXwrite    = 1'b0;
      EX_MEMwrite   = 1'b0;
      control_sel   = 1'b1;
      if_id_flush   = 1'b1;
      mem_wb_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign halted = (state_q == HALT);

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rst  (reset),
    .en_i (!PCwrite),
    .cnt_o(stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .rst  (reset),
    .en_i (br_flush),
    .cnt_o(flush_cnt)
  );

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================
// tb_pipeline_hazard_ctrl : directed self-checking bench
// Revision 1.0
// ============================================================
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_ex_memread;
  logic [4:0] id_ex_rd;
  logic [4:0] if_id_rs1;
  logic [4:0] if_id_rs2;
  logic       branch_taken;
  logic       dmem_req;
  logic       dmem_ready;
  logic       PCwrite, IF_IDwrite, ID_EXwrite, EX_MEMwrite;
  logic       control_sel, if_id_flush, mem_wb_bubble, halted;
  logic [2:0] stall_cnt;
  logic [2:0] flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  // {PCwrite, IF_IDwrite, ID_EXwrite, EX_MEMwrite, control_sel, if_id_flush, mem_wb_bubble, halted}
  localparam logic [7:0] O_RESET  = 8'b0000_1110;
  localparam logic [7:0] O_NORMAL = 8'b1111_0000;
  localparam logic [7:0] O_LDUSE  = 8'b0011_1000;
  localparam logic [7:0] O_BRANCH = 8'b1111_1100;
  localparam logic [7:0] O_FREEZE = 8'b0000_0010;

  logic [7:0] outs;
  assign outs = {PCwrite, IF_IDwrite, ID_EXwrite, EX_MEMwrite,
                 control_sel, if_id_flush, mem_wb_bubble, halted};

  pipeline_hazard_ctrl #(
    .TIMEOUT_W  (8),
    .MEM_TIMEOUT(4),
    .CNT_W      (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_ex_memread(id_ex_memread),
    .id_ex_rd     (id_ex_rd),
    .if_id_rs1    (if_id_rs1),
    .if_id_rs2    (if_id_rs2),
    .branch_taken (branch_taken),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .PCwrite      (PCwrite),
    .IF_IDwrite   (IF_IDwrite),
    .ID_EXwrite   (ID_EXwrite),
    .EX_MEMwrite  (EX_MEMwrite),
    .control_sel  (control_sel),
    .if_id_flush  (if_id_flush),
    .mem_wb_bubble(mem_wb_bubble),
    .halted       (halted),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_ex_memread = 1'b0;
    id_ex_rd      = 5'd0;
    if_id_rs1     = 5'd0;
    if_id_rs2     = 5'd0;
    branch_taken  = 1'b0;
    dmem_req      = 1'b0;
    dmem_ready    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_outs", 32'(outs), 32'(O_RESET));
    chk("reset_stall", 32'(stall_cnt), 32'd0);
    chk("reset_flush", 32'(flush_cnt), 32'd0);
    reset = 1'b0;
    #1;
    chk("run_idle", 32'(outs), 32'(O_NORMAL));

    // load-use on rs2: exactly one stall cycle
    @(negedge clk);
    id_ex_memread = 1'b1; id_ex_rd = 5'd5; if_id_rs2 = 5'd5;
    #1 chk("lduse_rs2", 32'(outs), 32'(O_LDUSE));
    @(negedge clk);
    id_ex_memread = 1'b0;
    #1 chk("lduse_release", 32'(outs), 32'(O_NORMAL));
    chk("lduse_stall1", 32'(stall_cnt), 32'd1);

    // x0 destination never stalls
    @(negedge clk);
    id_ex_memread = 1'b1; id_ex_rd = 5'd0; if_id_rs1 = 5'd0; if_id_rs2 = 5'd0;
    #1 chk("lduse_x0", 32'(outs), 32'(O_NORMAL));
    @(negedge clk);
    idle();
    #1 chk("lduse_x0_stall", 32'(stall_cnt), 32'd1);

    // load-use on rs1
    id_ex_memread = 1'b1; id_ex_rd = 5'd7; if_id_rs1 = 5'd7; if_id_rs2 = 5'd2;
    #1 chk("lduse_rs1", 32'(outs), 32'(O_LDUSE));
    @(negedge clk);
    idle();
    #1 chk("lduse_stall2", 32'(stall_cnt), 32'd2);

    // branch wins over simultaneous load-use
    branch_taken = 1'b1; id_ex_memread = 1'b1; id_ex_rd = 5'd3; if_id_rs1 = 5'd3;
    #1 chk("br_lduse", 32'(outs), 32'(O_BRANCH));
    @(negedge clk);
    idle();
    #1 chk("br_flush1", 32'(flush_cnt), 32'd1);
    chk("br_stall_kept", 32'(stall_cnt), 32'd2);

    // memory wait 3 cycles with branch pending, then ready applies the flush
    dmem_req = 1'b1; dmem_ready = 1'b0; branch_taken = 1'b1;
    #1 chk("mw_freeze1", 32'(outs), 32'(O_FREEZE));
    @(negedge clk); #1 chk("mw_freeze2", 32'(outs), 32'(O_FREEZE));
    @(negedge clk); #1 chk("mw_freeze3", 32'(outs), 32'(O_FREEZE));
    @(negedge clk);
    dmem_ready = 1'b1;
    #1 chk("mw_ready_br", 32'(outs), 32'(O_BRANCH));
    @(negedge clk);
    idle();
    #1 chk("mw_stall5", 32'(stall_cnt), 32'd5);
    chk("mw_flush2", 32'(flush_cnt), 32'd2);
    chk("mw_back_run", 32'(outs), 32'(O_NORMAL));

    // reset asserted mid memory wait
    dmem_req = 1'b1; dmem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("rst_midwait", 32'(outs), 32'(O_RESET));
    @(negedge clk);
    idle();
    reset = 1'b0;
    #1 chk("rst_rel_outs", 32'(outs), 32'(O_NORMAL));
    chk("rst_rel_stall", 32'(stall_cnt), 32'd0);
    chk("rst_rel_flush", 32'(flush_cnt), 32'd0);

    // ready arriving on the timeout cycle returns to RUN
    dmem_req = 1'b1; dmem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    dmem_ready = 1'b1;
    #1 chk("to_ready_outs", 32'(outs), 32'(O_NORMAL));
    @(negedge clk);
    idle();
    #1 chk("to_ready_nohalt", 32'(halted), 32'd0);
    chk("to_ready_run", 32'(outs), 32'(O_NORMAL));
    chk("to_ready_stall", 32'(stall_cnt), 32'd3);

    // timeout: four unready wait cycles then HALT
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    #1 chk("to_wait1", 32'(outs), 32'(O_FREEZE));
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1 chk("to_wait4_nohalt", 32'(halted), 32'd0);
    @(negedge clk);
    #1 chk("to_halted", 32'(halted), 32'd1);
    chk("to_halt_stall", 32'(stall_cnt), 32'd4);
    dmem_ready = 1'b1;
    #1 chk("halt_ready_ign", 32'({PCwrite, IF_IDwrite, ID_EXwrite, EX_MEMwrite, mem_wb_bubble, halted}),
           32'(6'b0000_11));
    @(negedge clk);
    #1 chk("halt_sticky", 32'(halted), 32'd1);
    chk("halt_stall5", 32'(stall_cnt), 32'd5);
    reset = 1'b1;
    #1 chk("halt_rst_clear", 32'(halted), 32'd0);
    @(negedge clk);
    idle();
    reset = 1'b0;
    #1 chk("halt_rst_outs", 32'(outs), 32'(O_NORMAL));

    // saturation: nine consecutive load-use stalls on a 3-bit counter
    id_ex_memread = 1'b1; id_ex_rd = 5'd9; if_id_rs1 = 5'd9;
    for (int i = 0; i < 9; i++) @(negedge clk);
    idle();
    #1 chk("sat_stall7", 32'(stall_cnt), 32'd7);
    id_ex_memread = 1'b1; id_ex_rd = 5'd9; if_id_rs2 = 5'd9;
    @(negedge clk);
    idle();
    #1 chk("sat_hold7", 32'(stall_cnt), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire
